// File: rtl/dcache_pkg.sv
// Shared types, defaults and address layout for the direct-mapped data cache.
// Optional misaligned-word exception: DCACHE_ALIGN_XCPT_EN.
package dcache_pkg;
  localparam int PC_WIDTH       = 32;
  localparam int REG_FILE_ADDR  = 5;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int DEF_LINE_WIDTH = 128;
  localparam int DEF_NUM_LINES  = 4;
  localparam int OFF_LSB        = 0;
  localparam int OFF_MSB        = 3;
  localparam int IDX_LSB        = 4;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } dcache_size_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    dcache_size_t          size;
    logic                  is_store;
  } dcache_request_t;

  typedef enum logic [1:0] {
    IDLE,
    EVICT,
    FILL,
    REPLAY
  } dcache_state_t;
endpackage

// File: rtl/dcache_tag_data_array.sv
// Tag, valid, dirty and line storage; combinational read, one write port.
// Feature macro DCACHE_ALIGN_XCPT_EN does not affect this block.
module dcache_tag_data_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int TAG_W      = 26,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  we,
  input  logic [TAG_W-1:0]      we_tag,
  input  logic [LINE_WIDTH-1:0] we_line,
  input  logic                  we_dirty,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_WIDTH-1:0] rd_line
);
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [TAG_W-1:0]      tag_d  [NUM_LINES];
  logic [LINE_WIDTH-1:0] line_q [NUM_LINES];
  logic [LINE_WIDTH-1:0] line_d [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = we_dirty;
      tag_d[idx]   = we_tag;
      line_d[idx]  = we_line;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];
endmodule

// File: rtl/dcache_top.sv
// Write-back direct-mapped data cache: hit path, miss FSM and WB staging.
// Define DCACHE_ALIGN_XCPT_EN to trap misaligned word accesses.
module dcache_top
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_dcache_valid,
  input  logic [PC_WIDTH-1:0]      req_dcache_pc,
  input  dcache_request_t          req_dcache_info,
  input  logic                     req_m_type_instr,
  input  logic                     req_r_type_instr,
  input  logic [REG_FILE_ADDR-1:0] req_dst_reg,
  output logic                     dcache_busy,
  output logic                     req_wb_valid,
  output logic [PC_WIDTH-1:0]      req_wb_pc,
  output logic [DATA_WIDTH-1:0]    req_wb_data,
  output logic [REG_FILE_ADDR-1:0] req_wb_dst_reg,
  output logic                     req_wb_rf_write,
  output logic [DATA_WIDTH-1:0]    cache_data_bypass,
  output logic                     req_mem_valid,
  output logic                     req_mem_is_store,
  output logic [ADDR_WIDTH-1:0]    req_mem_addr,
  output logic [LINE_WIDTH-1:0]    req_mem_data,
  input  logic                     rsp_mem_valid,
  input  logic [LINE_WIDTH-1:0]    rsp_mem_data,
  output logic                     xcpt_dcache
);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  dcache_state_t            state_q, state_d;
  dcache_request_t          cap_q, cap_d;
  logic [PC_WIDTH-1:0]      cap_pc_q, cap_pc_d;
  logic [REG_FILE_ADDR-1:0] cap_dst_q, cap_dst_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [PC_WIDTH-1:0]      wb_pc_q, wb_pc_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
  logic [REG_FILE_ADDR-1:0] wb_dst_q, wb_dst_d;
  logic                     wb_rf_q, wb_rf_d;
  logic                     xcpt_q, xcpt_d;

  dcache_request_t          acc;
  logic [PC_WIDTH-1:0]      acc_pc;
  logic [REG_FILE_ADDR-1:0] acc_dst;
  logic [IDX_W-1:0]         acc_idx;
  logic [TAG_W-1:0]         acc_tag;
  logic [OFF_MSB:OFF_LSB]   acc_off;
  logic                     idle, accept, is_mem;
  logic                     misalign, hit, do_acc;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic [LINE_WIDTH-1:0]    st_line;
  logic                     rd_valid, rd_dirty;
  logic [TAG_W-1:0]         rd_tag;
  logic [LINE_WIDTH-1:0]    rd_line;
  logic                     arr_we, arr_dirty;
  logic [TAG_W-1:0]         arr_tag;
  logic [LINE_WIDTH-1:0]    arr_line;

  assign idle    = (state_q == IDLE);
  assign accept  = req_dcache_valid & idle;
  assign is_mem  = req_m_type_instr;
  // Outside IDLE the array is steered by the captured miss request.
  assign acc     = idle ? req_dcache_info : cap_q;
  assign acc_pc  = idle ? req_dcache_pc : cap_pc_q;
  assign acc_dst = idle ? req_dst_reg : cap_dst_q;
  assign acc_idx = acc.addr[TAG_LSB-1:IDX_LSB];
  assign acc_tag = acc.addr[ADDR_WIDTH-1:TAG_LSB];
  assign acc_off = acc.addr[OFF_MSB:OFF_LSB];
  assign hit     = rd_valid & (rd_tag == acc_tag);

`ifdef DCACHE_ALIGN_XCPT_EN
  assign misalign = (acc.size == SZ_WORD) &
                    (acc.addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  dcache_tag_data_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WIDTH (LINE_WIDTH),
    .TAG_W      (TAG_W)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .idx      (acc_idx),
    .we       (arr_we),
    .we_tag   (arr_tag),
    .we_line  (arr_line),
    .we_dirty (arr_dirty),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line)
  );

  always_comb begin
    ld_data = '0;
    st_line = rd_line;
    if (acc.size == SZ_WORD) begin
      ld_data = rd_line[{acc_off[3:2], 5'b0} +: 32];
      st_line[{acc_off[3:2], 5'b0} +: 32] = acc.data;
    end else begin
      ld_data[7:0] = rd_line[{acc_off, 3'b0} +: 8];
      st_line[{acc_off, 3'b0} +: 8] = acc.data[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      cap_pc_q   <= '0;
      cap_dst_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_data_q  <= '0;
      wb_dst_q   <= '0;
      wb_rf_q    <= 1'b0;
      xcpt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      cap_pc_q   <= cap_pc_d;
      cap_dst_q  <= cap_dst_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_data_q  <= wb_data_d;
      wb_dst_q   <= wb_dst_d;
      wb_rf_q    <= wb_rf_d;
      xcpt_q     <= xcpt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept & is_mem & ~misalign & ~hit)
          state_d = (rd_valid & rd_dirty) ? EVICT : FILL;
      end
      EVICT:   if (rsp_mem_valid) state_d = FILL;
      FILL:    if (rsp_mem_valid) state_d = REPLAY;
      REPLAY:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_d      = cap_q;
    cap_pc_d   = cap_pc_q;
    cap_dst_d  = cap_dst_q;
    wb_valid_d = 1'b0;
    wb_pc_d    = wb_pc_q;
    wb_data_d  = wb_data_q;
    wb_dst_d   = wb_dst_q;
    wb_rf_d    = 1'b0;
    xcpt_d     = 1'b0;
    arr_we     = 1'b0;
    arr_tag    = acc_tag;
    arr_line   = st_line;
    arr_dirty  = 1'b1;
    do_acc     = (state_q == REPLAY) |
                 (accept & is_mem & ~misalign & hit);
    if (accept & is_mem & misalign) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = req_dcache_pc;
      wb_dst_d   = req_dst_reg;
      xcpt_d     = 1'b1;
    end else if (accept & ~is_mem & req_r_type_instr) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = req_dcache_pc;
      wb_dst_d   = req_dst_reg;
      wb_data_d  = req_dcache_info.data;
      wb_rf_d    = 1'b1;
    end else if (accept & is_mem & ~hit) begin
      cap_d     = req_dcache_info;
      cap_pc_d  = req_dcache_pc;
      cap_dst_d = req_dst_reg;
    end
    if (do_acc) begin
      wb_valid_d = 1'b1;
      wb_pc_d    = acc_pc;
      wb_dst_d   = acc_dst;
      wb_data_d  = acc.is_store ? acc.data : ld_data;
      wb_rf_d    = ~acc.is_store;
      arr_we     = acc.is_store;
    end
    if ((state_q == FILL) & rsp_mem_valid) begin
      arr_we    = 1'b1;
      arr_line  = rsp_mem_data;
      arr_dirty = 1'b0;
    end
  end

  always_comb begin
    req_mem_valid    = 1'b0;
    req_mem_is_store = 1'b0;
    req_mem_addr     = {acc.addr[ADDR_WIDTH-1:IDX_LSB],
                        {IDX_LSB{1'b0}}};
    req_mem_data     = rd_line;
    if (state_q == EVICT) begin
      req_mem_valid    = 1'b1;
      req_mem_is_store = 1'b1;
      req_mem_addr     = {rd_tag, acc_idx, {IDX_LSB{1'b0}}};
    end else if (state_q == FILL) begin
      req_mem_valid = 1'b1;
    end
  end

  assign dcache_busy       = ~idle;
  assign req_wb_valid      = wb_valid_q;
  assign req_wb_pc         = wb_pc_q;
  assign req_wb_data       = wb_data_q;
  assign req_wb_dst_reg    = wb_dst_q;
  assign req_wb_rf_write   = wb_rf_q;
  assign cache_data_bypass = wb_data_q;
  assign xcpt_dcache       = xcpt_q;
endmodule

// File: tb/tb_dcache_top.sv
// Bench for dcache_top: directed scenarios then random traffic against a
// flat-memory reference with a simple tag directory and a bench-side memory.
module tb_dcache_top;
  import dcache_pkg::*;

  localparam int LW = 128;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                     reset;
  logic                     req_dcache_valid;
  logic [PC_WIDTH-1:0]      req_dcache_pc;
  dcache_request_t          req_dcache_info;
  logic                     req_m_type_instr;
  logic                     req_r_type_instr;
  logic [REG_FILE_ADDR-1:0] req_dst_reg;
  logic                     dcache_busy;
  logic                     req_wb_valid;
  logic [PC_WIDTH-1:0]      req_wb_pc;
  logic [31:0]              req_wb_data;
  logic [REG_FILE_ADDR-1:0] req_wb_dst_reg;
  logic                     req_wb_rf_write;
  logic [31:0]              cache_data_bypass;
  logic                     req_mem_valid;
  logic                     req_mem_is_store;
  logic [31:0]              req_mem_addr;
  logic [LW-1:0]            req_mem_data;
  logic                     rsp_mem_valid;
  logic [LW-1:0]            rsp_mem_data;
  logic                     xcpt_dcache;

  dcache_top dut (
    .clock             (clock),
    .reset             (reset),
    .req_dcache_valid  (req_dcache_valid),
    .req_dcache_pc     (req_dcache_pc),
    .req_dcache_info   (req_dcache_info),
    .req_m_type_instr  (req_m_type_instr),
    .req_r_type_instr  (req_r_type_instr),
    .req_dst_reg       (req_dst_reg),
    .dcache_busy       (dcache_busy),
    .req_wb_valid      (req_wb_valid),
    .req_wb_pc         (req_wb_pc),
    .req_wb_data       (req_wb_data),
    .req_wb_dst_reg    (req_wb_dst_reg),
    .req_wb_rf_write   (req_wb_rf_write),
    .cache_data_bypass (cache_data_bypass),
    .req_mem_valid     (req_mem_valid),
    .req_mem_is_store  (req_mem_is_store),
    .req_mem_addr      (req_mem_addr),
    .req_mem_data      (req_mem_data),
    .rsp_mem_valid     (rsp_mem_valid),
    .rsp_mem_data      (rsp_mem_data),
    .xcpt_dcache       (xcpt_dcache)
  );

  int n_vec = 0;
  int n_err = 0;

  // truth: architectural byte memory; dram: what the bench memory holds
  logic [7:0]  truth [int unsigned];
  logic [7:0]  dram  [int unsigned];
  bit          mv [4];
  bit          md [4];
  int unsigned mt [4];

  task automatic chk(input string tag, input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seed_b(int unsigned a);
    return 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  function automatic logic [7:0] t_rd(int unsigned a);
    return truth.exists(a) ? truth[a] : seed_b(a);
  endfunction

  function automatic logic [7:0] d_rd(int unsigned a);
    return dram.exists(a) ? dram[a] : seed_b(a);
  endfunction

  function automatic logic [LW-1:0] t_line(int unsigned la);
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = t_rd(la + i);
    return l;
  endfunction

  function automatic logic [LW-1:0] d_line(int unsigned la);
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = d_rd(la + i);
    return l;
  endfunction

  // Dirty contents lost by a reset fall back to what memory holds.
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      if (mv[i] && md[i])
        for (int b = 0; b < 16; b++) begin
          truth[(mt[i] << 6) + (i << 4) + b] =
            d_rd((mt[i] << 6) + (i << 4) + b);
        end
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rsp_mem_valid = 1'b0;
    req_dcache_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_op(input bit r_t, input bit st, input bit wd,
                       input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] wdata, output int ntx);
    int unsigned ea, la, idx, tg;
    bit xc, hit, exp_rf, got, in_tx;
    logic [31:0] exp_d, tx_addr;
    logic [PC_WIDTH-1:0] pc;
    logic [REG_FILE_ADDR-1:0] dst;
    logic [31:0] q_addr [$];
    bit q_st [$];
    logic [LW-1:0] q_data [$];
    logic [31:0] e_addr;
    bit e_st, tx_st;
    logic [LW-1:0] e_data;
    int cyc, wait_n;
    xc = 1'b0;
    exp_d = data;
    exp_rf = 1'b1;
    pc = $urandom;
    dst = 5'($urandom);
    wdata = '0;
    if (!r_t) begin
      ea = wd ? (addr & ~32'h3) : addr;
`ifdef DCACHE_ALIGN_XCPT_EN
      xc = wd && (addr[1:0] != 2'b00);
`endif
      exp_rf = !st && !xc;
      if (!xc) begin
        la = ea & ~32'hF;
        idx = (ea >> 4) & 3;
        tg = ea >> 6;
        hit = mv[idx] && (mt[idx] == tg);
        if (!hit) begin
          if (mv[idx] && md[idx]) begin
            q_addr.push_back((mt[idx] << 6) | (idx << 4));
            q_st.push_back(1'b1);
            q_data.push_back(t_line((mt[idx] << 6) | (idx << 4)));
          end
          q_addr.push_back(la);
          q_st.push_back(1'b0);
          q_data.push_back('0);
          mv[idx] = 1'b1;
          mt[idx] = tg;
          md[idx] = 1'b0;
        end
        if (st) begin
          truth[ea] = data[7:0];
          if (wd) begin
            truth[ea + 1] = data[15:8];
            truth[ea + 2] = data[23:16];
            truth[ea + 3] = data[31:24];
          end
          md[idx] = 1'b1;
        end else if (wd) begin
          exp_d = {t_rd(ea + 3), t_rd(ea + 2), t_rd(ea + 1), t_rd(ea)};
        end else begin
          exp_d = {24'h0, t_rd(ea)};
        end
      end
    end
    @(negedge clock);
    chk("busy_before_req", dcache_busy, 1'b0);
    req_dcache_valid = 1'b1;
    req_dcache_pc = pc;
    req_dst_reg = dst;
    req_dcache_info.addr = addr;
    req_dcache_info.data = data;
    req_dcache_info.size = wd ? SZ_WORD : SZ_BYTE;
    req_dcache_info.is_store = st;
    req_m_type_instr = !r_t;
    req_r_type_instr = r_t;
    @(negedge clock);
    req_dcache_valid = 1'b0;
    req_dcache_info.addr = $urandom;
    got = 1'b0;
    in_tx = 1'b0;
    cyc = 0;
    ntx = 0;
    wait_n = 0;
    tx_addr = '0;
    tx_st = 1'b0;
    while (!got && cyc < 100) begin
      if (req_wb_valid) begin
        got = 1'b1;
        wdata = req_wb_data;
        rsp_mem_valid = 1'b0;
        chk("wb_pc", req_wb_pc, pc);
        chk("wb_dst", req_wb_dst_reg, dst);
        chk("wb_rf_write", req_wb_rf_write, exp_rf);
        if (exp_rf) chk("wb_data", req_wb_data, exp_d);
        chk("bypass", cache_data_bypass, req_wb_data);
        chk("xcpt", xcpt_dcache, xc);
        chk("mem_txns_left", q_addr.size(), 0);
        chk("busy_at_wb", dcache_busy, 1'b0);
      end else begin
        if (rsp_mem_valid) begin
          rsp_mem_valid = 1'b0;
        end else if (req_mem_valid) begin
          if (!in_tx) begin
            in_tx = 1'b1;
            wait_n = $urandom_range(0, 3);
            tx_addr = req_mem_addr;
            tx_st = req_mem_is_store;
            chk("mem_expected", q_addr.size() != 0, 1'b1);
            if (q_addr.size() != 0) begin
              e_addr = q_addr.pop_front();
              e_st = q_st.pop_front();
              e_data = q_data.pop_front();
              chk("mem_is_store", req_mem_is_store, e_st);
              chk("mem_addr", req_mem_addr, e_addr);
              if (e_st) chk("evict_data", req_mem_data, e_data);
            end
          end else begin
            chk("mem_hold_addr", req_mem_addr, tx_addr);
            chk("mem_hold_st", req_mem_is_store, tx_st);
          end
          if (wait_n == 0) begin
            if (req_mem_is_store) begin
              for (int b = 0; b < 16; b++)
                dram[req_mem_addr + b] = req_mem_data[8*b +: 8];
              rsp_mem_data = '0;
            end else begin
              rsp_mem_data = d_line(req_mem_addr);
            end
            rsp_mem_valid = 1'b1;
            in_tx = 1'b0;
            ntx++;
          end else begin
            wait_n--;
          end
        end
        @(negedge clock);
        cyc++;
      end
    end
    chk("wb_seen", got, 1'b1);
    if (got) begin
      @(negedge clock);
      chk("wb_pulse", req_wb_valid, 1'b0);
    end else begin
      do_reset();
    end
  endtask

  logic [31:0] w;
  int ntx, cyc;
  bit wbseen;

  initial begin
    reset = 1'b1;
    req_dcache_valid = 1'b0;
    req_dcache_pc = '0;
    req_dcache_info = '0;
    req_m_type_instr = 1'b0;
    req_r_type_instr = 1'b0;
    req_dst_reg = '0;
    rsp_mem_valid = 1'b0;
    rsp_mem_data = '0;
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = 0;
    end
    dram[32'h100] = 8'hEF;
    dram[32'h101] = 8'hBE;
    dram[32'h102] = 8'hAD;
    dram[32'h103] = 8'hDE;
    for (int i = 0; i < 4; i++) truth[32'h100 + i] = dram[32'h100 + i];
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", dcache_busy, 1'b0);
    chk("rst_wb_valid", req_wb_valid, 1'b0);
    chk("rst_mem_valid", req_mem_valid, 1'b0);
    chk("rst_xcpt", xcpt_dcache, 1'b0);

    do_op(1'b0, 1'b0, 1'b1, 32'h100, 32'h0, w, ntx);
    chk("cold_load_data", w, 32'hDEADBEEF);
    chk("cold_load_ntx", ntx, 1);

    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h12345678, w, ntx);
    chk("rtype_data", w, 32'h12345678);
    chk("rtype_ntx", ntx, 0);

    do_op(1'b0, 1'b1, 1'b0, 32'h101, 32'h000000AB, w, ntx);
    chk("store_hit_ntx", ntx, 0);
    do_op(1'b0, 1'b0, 1'b0, 32'h101, 32'h0, w, ntx);
    chk("load_byte_data", w, 32'h000000AB);
    chk("load_byte_ntx", ntx, 0);

    do_op(1'b0, 1'b0, 1'b1, 32'h140, 32'h0, w, ntx);
    chk("evict_fill_ntx", ntx, 2);

    do_op(1'b0, 1'b0, 1'b1, 32'h102, 32'h0, w, ntx);
`ifdef DCACHE_ALIGN_XCPT_EN
    chk("misalign_ntx", ntx, 0);
`else
    chk("unaligned_word", w, 32'hDEADABEF);
    chk("unaligned_ntx", ntx, 1);
`endif

    @(negedge clock);
    req_dcache_valid = 1'b1;
    req_dcache_info.addr = 32'h180;
    req_dcache_info.size = SZ_WORD;
    req_dcache_info.is_store = 1'b0;
    req_m_type_instr = 1'b1;
    req_r_type_instr = 1'b0;
    @(negedge clock);
    req_dcache_valid = 1'b0;
    cyc = 0;
    while (!req_mem_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("rst_fill_seen", req_mem_valid, 1'b1);
    chk("rst_fill_addr", req_mem_addr, 32'h180);
    chk("rst_fill_st", req_mem_is_store, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("rst_fill_busy", dcache_busy, 1'b0);
    chk("rst_fill_memv", req_mem_valid, 1'b0);
    rsp_mem_valid = 1'b1;
    rsp_mem_data = '1;
    @(negedge clock);
    rsp_mem_valid = 1'b0;
    wbseen = 1'b0;
    repeat (4) begin
      wbseen = wbseen | req_wb_valid;
      @(negedge clock);
    end
    chk("late_rsp_no_wb", wbseen, 1'b0);
    chk("late_rsp_busy", dcache_busy, 1'b0);
    chk("late_rsp_memv", req_mem_valid, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 32'h100, 32'h0, w, ntx);
    chk("line_invalid_ntx", ntx, 1);

    for (int k = 0; k < 300; k++) begin
      do_op($urandom_range(0, 5) == 0, $urandom_range(0, 9) < 4,
            1'($urandom), ($urandom_range(4, 6) << 6) |
            ($urandom_range(0, 3) << 4) | $urandom_range(0, 15),
            $urandom, w, ntx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
